// File: rtl/adaptive_traffic_ctrl_n_if.sv
// -----------------------------------------------------------------------------
// adaptive_traffic_ctrl_n_if
//
// Bundles the signals between the sensor-conditioning side, the controller and
// the lamp drivers. The controller connects to the slave modport. Whoever drives
// the timebase, sensors and emergency request connects to the master modport.
//
// Signals:
//   tick        master->slave  one-cycle timebase strobe
//   sens        master->slave  NUM_DIR*SENS_W packed densities, approach i at [i*SENS_W +: SENS_W]
//   emerg_req   master->slave  level-sensitive emergency request
//   emerg_dir   master->slave  approach to receive the emergency green
//   lights      slave->master  NUM_DIR*3 lamp codes, approach i at [i*3 +: 3]
//                              (001 green, 010 orange, 100 red)
//   active_dir  slave->master  approach holding green or orange
//   phase       slave->master  00 GREEN, 01 ORANGE, 10 ALLRED
// -----------------------------------------------------------------------------
interface adaptive_traffic_ctrl_n_if #(
    parameter int NUM_DIR = 4,
    parameter int SENS_W  = 2
);
    localparam int DIR_W = $clog2(NUM_DIR);

    logic                      tick;
    logic [NUM_DIR*SENS_W-1:0] sens;
    logic                      emerg_req;
    logic [DIR_W-1:0]          emerg_dir;
    logic [NUM_DIR*3-1:0]      lights;
    logic [DIR_W-1:0]          active_dir;
    logic [1:0]                phase;

    modport master (
        output tick, sens, emerg_req, emerg_dir,
        input  lights, active_dir, phase
    );

    modport slave (
        input  tick, sens, emerg_req, emerg_dir,
        output lights, active_dir, phase
    );
endinterface

// File: rtl/adaptive_traffic_ctrl_n.sv
// -----------------------------------------------------------------------------
// adaptive_traffic_ctrl_n
//
// N-approach adaptive traffic-light controller. Green rotates through the
// approaches, with the next green going to the busiest waiting approach. A
// green approach that is strictly busier than every other approach may extend
// its slot, up to MAX_GREEN ticks in total. Every handover passes through
// ORANGE and then an all-red clearance. An emergency request pre-empts a
// foreign green immediately, and it holds green on its own approach.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   adaptive_traffic_ctrl_n_if.slave
//         (tick, sens, emerg_req, emerg_dir in; lights, active_dir, phase out)
//
// Outputs are decoded purely from registered state. No input reaches an
// output combinationally.
// -----------------------------------------------------------------------------
module adaptive_traffic_ctrl_n #(
    parameter int NUM_DIR     = 4,
    parameter int SENS_W      = 2,
    parameter int CNT_W       = 6,
    parameter int GREEN_TIME  = 30,
    parameter int ORANGE_TIME = 3,
    parameter int ALLRED_TIME = 1,
    parameter int MAX_GREEN   = 60
) (
    input  logic                      clk,
    input  logic                      rst,
    adaptive_traffic_ctrl_n_if.slave  bus
);
    localparam int DIR_W = $clog2(NUM_DIR);

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_TIME);
    localparam logic [CNT_W-1:0] ORANGE_LOAD = CNT_W'(ORANGE_TIME);
    localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_TIME);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_ORANGE = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    phase_e           phase_q;
    logic [DIR_W-1:0] cur_dir_q;
    logic [DIR_W-1:0] nxt_dir_q;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] green_acc_q;

    // -------------------------------------------------------------------------
    // Unpack the per-approach density values.
    // -------------------------------------------------------------------------
    logic [SENS_W-1:0] sens_arr [NUM_DIR];

    for (genvar g = 0; g < NUM_DIR; g++) begin : g_sens
        assign sens_arr[g] = bus.sens[g*SENS_W +: SENS_W];
    end

    // -------------------------------------------------------------------------
    // Next-direction selection. Scan cur_dir+1, cur_dir+2, ... modulo NUM_DIR.
    // best_other is the maximum over all approaches except cur_dir. It serves
    // the selection and also the "strictly busiest" test for extension.
    // -------------------------------------------------------------------------
    logic [DIR_W-1:0]  sel_dir;
    logic [SENS_W-1:0] best_other;
    logic [DIR_W-1:0]  scan_dir;
    int                scan_idx;
    logic              cur_dominant;

    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        sel_dir    = cur_dir_q;
        best_other = '0;
        scan_idx   = 0;
        scan_dir   = '0;
        for (int k = 1; k < NUM_DIR; k++) begin
            scan_idx = int'(cur_dir_q) + k;
            if (scan_idx >= NUM_DIR) begin
                scan_idx = scan_idx - NUM_DIR;
            end
            scan_dir = DIR_W'(scan_idx);
            // A later candidate only wins with a strictly larger value, so a
            // tie stays with the approach met first in scan order.
            if (k == 1 || sens_arr[scan_dir] > best_other) begin
                best_other = sens_arr[scan_dir];
                sel_dir    = scan_dir;
            end
        end
        cur_dominant = sens_arr[cur_dir_q] > best_other;
    end

    // -------------------------------------------------------------------------
    // Timer and accumulator helpers
    // -------------------------------------------------------------------------
    logic             phase_end;
    logic             ext_ok;
    logic [CNT_W-1:0] acc_inc;

    assign phase_end = bus.tick && (timer_q == CNT_W'(1));
    // The cap check uses the accumulated green before this tick is counted.
    assign ext_ok    = (int'(green_acc_q) + GREEN_TIME) <= MAX_GREEN;
    // The accumulator saturates instead of wrapping, so a long green can never
    // look short again.
    assign acc_inc   = (green_acc_q == '1) ? green_acc_q : green_acc_q + CNT_W'(1);

    // -------------------------------------------------------------------------
    // Phase state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is tested inside the clocked block, so it is synchronous
        // and takes effect only on a rising edge.
        if (rst) begin
            // NOTE: non-blocking assignments, so every register here samples
            // the pre-edge values of the others.
            phase_q     <= PH_GREEN;
            cur_dir_q   <= '0;
            nxt_dir_q   <= '0;
            timer_q     <= GREEN_LOAD;
            green_acc_q <= '0;
        end else if (phase_q == PH_GREEN && bus.emerg_req) begin
            // Emergency is evaluated every cycle, independent of tick.
            if (cur_dir_q != bus.emerg_dir) begin
                phase_q   <= PH_ORANGE;
                timer_q   <= ORANGE_LOAD;
                nxt_dir_q <= bus.emerg_dir;
            end else begin
                // Green already belongs to the emergency approach. Freeze the
                // slot at its start so that nothing can end it.
                timer_q     <= GREEN_LOAD;
                green_acc_q <= '0;
            end
        end else if (bus.tick) begin
            if (phase_end) begin
                case (phase_q)
                    PH_GREEN: begin
                        green_acc_q <= acc_inc;
                        if (cur_dominant && ext_ok) begin
                            timer_q <= GREEN_LOAD;
                        end else begin
                            phase_q   <= PH_ORANGE;
                            timer_q   <= ORANGE_LOAD;
                            nxt_dir_q <= sel_dir;
                        end
                    end
                    PH_ORANGE: begin
                        phase_q <= PH_ALLRED;
                        timer_q <= ALLRED_LOAD;
                    end
                    PH_ALLRED: begin
                        phase_q     <= PH_GREEN;
                        timer_q     <= GREEN_LOAD;
                        green_acc_q <= '0;
                        cur_dir_q   <= bus.emerg_req ? bus.emerg_dir : nxt_dir_q;
                    end
                    default: begin
                        // Unreachable encoding. Recover into a safe all-red
                        // clearance before any green is shown.
                        phase_q <= PH_ALLRED;
                        timer_q <= ALLRED_LOAD;
                    end
                endcase
            end else begin
                timer_q <= timer_q - CNT_W'(1);
                if (phase_q == PH_GREEN) begin
                    green_acc_q <= acc_inc;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Lamp decode: only cur_dir can be non-red, and only in GREEN or ORANGE.
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < NUM_DIR; g++) begin : g_lamp
        assign bus.lights[g*3 +: 3] =
            (cur_dir_q != DIR_W'(g))  ? 3'b100 :
            (phase_q   == PH_GREEN)   ? 3'b001 :
            (phase_q   == PH_ORANGE)  ? 3'b010 : 3'b100;
    end

    assign bus.active_dir = cur_dir_q;
    assign bus.phase      = phase_q;

endmodule

// File: tb/tb_adaptive_traffic_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_adaptive_traffic_ctrl_n
//
// Self-checking bench for adaptive_traffic_ctrl_n at default parameters.
//
// A behavioural model tracks the current phase, the owning approach and the
// number of ticks elapsed in the current slot. The outputs are compared
// against this model on every falling edge. Directed sequences also pin the
// phase lengths and the handover order with literal expectations.
// -----------------------------------------------------------------------------
module tb_adaptive_traffic_ctrl_n;
    localparam int NUM_DIR     = 4;
    localparam int SENS_W      = 2;
    localparam int CNT_W       = 6;
    localparam int GREEN_TIME  = 30;
    localparam int ORANGE_TIME = 3;
    localparam int ALLRED_TIME = 1;
    localparam int MAX_GREEN   = 60;
    localparam int DIR_W       = $clog2(NUM_DIR);
    localparam int SENS_TOT    = NUM_DIR * SENS_W;
    localparam int ACC_MAX     = (1 << CNT_W) - 1;
    localparam int SPAN_BUDGET = 400;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    adaptive_traffic_ctrl_n_if #(.NUM_DIR(NUM_DIR), .SENS_W(SENS_W)) tb_if ();

    adaptive_traffic_ctrl_n #(
        .NUM_DIR    (NUM_DIR),
        .SENS_W     (SENS_W),
        .CNT_W      (CNT_W),
        .GREEN_TIME (GREEN_TIME),
        .ORANGE_TIME(ORANGE_TIME),
        .ALLRED_TIME(ALLRED_TIME),
        .MAX_GREEN  (MAX_GREEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(tb_if)
    );

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Tick driver: 0 = every cycle, 1 = one in four, 2 = random
    // -------------------------------------------------------------------------
    int tick_mode = 0;
    int tick_cnt  = 0;

    always @(posedge clk) begin
        #1;
        tick_cnt++;
        case (tick_mode)
            0:       tb_if.tick = 1'b1;
            1:       tb_if.tick = (tick_cnt % 4 == 0);
            default: tb_if.tick = ($urandom_range(0, 3) != 0);
        endcase
    end

    // -------------------------------------------------------------------------
    // Behavioural model. Phase codes: 0 green, 1 orange, 2 all-red.
    // -------------------------------------------------------------------------
    int m_phase;
    int m_dir;
    int m_nxt;
    int m_elapsed;
    int m_acc;
    bit model_valid = 1'b0;

    function automatic int phase_len(input int ph);
        case (ph)
            0:       return GREEN_TIME;
            1:       return ORANGE_TIME;
            default: return ALLRED_TIME;
        endcase
    endfunction

    function automatic int sens_of(input int i);
        return int'((tb_if.sens >> (i * SENS_W)) & SENS_TOT'((1 << SENS_W) - 1));
    endfunction

    function automatic int max_other(input int cur);
        int best;
        best = -1;
        for (int i = 0; i < NUM_DIR; i++)
            if (i != cur && sens_of(i) > best) best = sens_of(i);
        return best;
    endfunction

    // Find the largest waiting value, then return the first approach in
    // rotation order after cur that carries it.
    function automatic int pick_next(input int cur);
        int best;
        int d;
        best = max_other(cur);
        for (int k = 1; k < NUM_DIR; k++) begin
            d = (cur + k) % NUM_DIR;
            if (sens_of(d) == best) return d;
        end
        return cur;
    endfunction

    function automatic logic [NUM_DIR*3-1:0] model_lights(input int ph, input int dir);
        logic [NUM_DIR*3-1:0] l;
        for (int i = 0; i < NUM_DIR; i++) begin
            if (i == dir && ph == 0)      l[i*3 +: 3] = 3'b001;
            else if (i == dir && ph == 1) l[i*3 +: 3] = 3'b010;
            else                          l[i*3 +: 3] = 3'b100;
        end
        return l;
    endfunction

    always @(posedge clk) begin
        bit last;
        int old_acc;
        if (rst) begin
            m_phase = 0; m_dir = 0; m_nxt = 0; m_elapsed = 0; m_acc = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (m_phase == 0 && tb_if.emerg_req) begin
                if (m_dir != int'(tb_if.emerg_dir)) begin
                    m_phase = 1; m_elapsed = 0; m_nxt = int'(tb_if.emerg_dir);
                end else begin
                    m_elapsed = 0; m_acc = 0;
                end
            end else if (tb_if.tick) begin
                last = (m_elapsed == phase_len(m_phase) - 1);
                if (m_phase == 0) begin
                    old_acc = m_acc;
                    m_acc   = (m_acc < ACC_MAX) ? m_acc + 1 : ACC_MAX;
                    if (!last)
                        m_elapsed++;
                    else if (sens_of(m_dir) > max_other(m_dir) && old_acc + GREEN_TIME <= MAX_GREEN)
                        m_elapsed = 0;
                    else begin
                        m_phase = 1; m_elapsed = 0; m_nxt = pick_next(m_dir);
                    end
                end else if (m_phase == 1) begin
                    if (!last) m_elapsed++;
                    else begin m_phase = 2; m_elapsed = 0; end
                end else begin
                    if (!last) m_elapsed++;
                    else begin
                        m_dir     = tb_if.emerg_req ? int'(tb_if.emerg_dir) : m_nxt;
                        m_phase   = 0;
                        m_elapsed = 0;
                        m_acc     = 0;
                    end
                end
            end
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (model_valid) begin
            check("cyc lights", 32'(tb_if.lights), 32'(model_lights(m_phase, m_dir)));
            check("cyc phase", 32'(tb_if.phase), 32'(m_phase));
            check("cyc active_dir", 32'(tb_if.active_dir), 32'(m_dir));
        end
    end

    // -------------------------------------------------------------------------
    // Directed helpers
    // -------------------------------------------------------------------------
    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    // Counts consecutive falling edges, starting at the current one, on which
    // phase and active_dir keep their current values. Returns at the first
    // falling edge that differs.
    task automatic span(output int ph, output int dir, output int n);
        ph  = int'(tb_if.phase);
        dir = int'(tb_if.active_dir);
        n   = 0;
        do begin
            n++;
            @(negedge clk);
        end while (int'(tb_if.phase) == ph && int'(tb_if.active_dir) == dir && n < SPAN_BUDGET);
    endtask

    task automatic expect_span(input string name, input int ph, input int dir, input int len);
        int a_ph, a_dir, a_n;
        span(a_ph, a_dir, a_n);
        check({name, " phase"}, 32'(a_ph), 32'(ph));
        check({name, " dir"}, 32'(a_dir), 32'(dir));
        check({name, " cycles"}, 32'(a_n), 32'(len));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        int a_ph, a_dir, a_n;
        bit found;

        tb_if.sens      = '0;
        tb_if.emerg_req = 1'b0;
        tb_if.emerg_dir = '0;

        // 1. Defaults, all sensors 0: plain rotation 0,1,2,3,0
        do_reset();
        @(negedge clk);
        check("reset lights", 32'(tb_if.lights), 32'(12'b100_100_100_001));
        check("reset phase", 32'(tb_if.phase), 32'd0);
        check("reset active_dir", 32'(tb_if.active_dir), 32'd0);
        for (int d = 0; d < NUM_DIR; d++) begin
            expect_span("rot green", 0, d, 30);
            expect_span("rot orange", 1, d, 3);
            expect_span("rot allred", 2, d, 1);
        end
        check("rot wrap dir", 32'(tb_if.active_dir), 32'd0);
        check("rot wrap phase", 32'(tb_if.phase), 32'd0);

        // 2. Dir0 strictly busiest: one extension, then cap. Tie 1/1/1 -> dir1
        tb_if.sens = 8'b01_01_01_11;
        do_reset();
        @(negedge clk);
        expect_span("ext green", 0, 0, 60);
        expect_span("ext orange", 1, 0, 3);
        expect_span("ext allred", 2, 0, 1);
        expect_span("ext next", 0, 1, 30);

        // 3. A=0 B=1 C=3 D=3: C wins the tie in scan order
        tb_if.sens = 8'b11_11_01_00;
        do_reset();
        @(negedge clk);
        expect_span("tie green", 0, 0, 30);
        expect_span("tie orange", 1, 0, 3);
        expect_span("tie allred", 2, 0, 1);
        expect_span("tie next", 0, 2, 30);

        // 4. Emergency for dir2 at cycle 10 of dir0 green
        tb_if.sens = '0;
        do_reset();
        repeat (9) begin @(posedge clk); #1; end
        tb_if.emerg_req = 1'b1;
        tb_if.emerg_dir = DIR_W'(2);
        @(negedge clk);
        check("emerg cycle10 phase", 32'(tb_if.phase), 32'd0);
        @(negedge clk);
        check("emerg cycle11 phase", 32'(tb_if.phase), 32'd1);
        expect_span("emerg orange", 1, 0, 3);
        expect_span("emerg allred", 2, 0, 1);
        repeat (100) @(negedge clk);
        check("emerg hold phase", 32'(tb_if.phase), 32'd0);
        check("emerg hold dir", 32'(tb_if.active_dir), 32'd2);
        check("emerg hold lights", 32'(tb_if.lights), 32'(12'b100_001_100_100));
        @(posedge clk); #1;
        tb_if.emerg_req = 1'b0;
        @(negedge clk);
        expect_span("release green", 0, 2, 30);
        expect_span("release orange", 1, 2, 3);
        expect_span("release allred", 2, 2, 1);
        check("release next dir", 32'(tb_if.active_dir), 32'd3);

        // 5. tick 1-in-4: every phase stretched four times
        tick_mode = 1;
        do_reset();
        @(negedge clk);
        span(a_ph, a_dir, a_n);
        check("slow first phase", 32'(a_ph), 32'd0);
        expect_span("slow orange", 1, 0, 12);
        expect_span("slow allred", 2, 0, 4);
        expect_span("slow green", 0, 1, 120);

        // 6. Reset in the middle of dir3 orange
        tick_mode = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (tb_if.phase == 2'b01 && int'(tb_if.active_dir) == 3) found = 1'b1;
        end
        check("reached dir3 orange", 32'(found), 32'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("pre-rst orange", 32'(tb_if.phase), 32'd1);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("mid-rst phase", 32'(tb_if.phase), 32'd0);
        check("mid-rst dir", 32'(tb_if.active_dir), 32'd0);
        check("mid-rst lights", 32'(tb_if.lights), 32'(12'b100_100_100_001));
        expect_span("mid-rst green", 0, 0, 30);

        // 7. Randomised traffic, ticks, emergencies and resets against the model
        tick_mode = 2;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 39) == 0) tb_if.sens = SENS_TOT'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                tb_if.emerg_req = ~tb_if.emerg_req;
                tb_if.emerg_dir = DIR_W'($urandom_range(0, NUM_DIR - 1));
            end
        end
        @(posedge clk); #1;
        rst             = 1'b0;
        tb_if.emerg_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adaptive_traffic_ctrl_n.md
# adaptive_traffic_ctrl_n

Parametrised N-approach adaptive traffic-light controller for the intersection controller family. It replaces the fixed four-way controller that depended on an external load/count counter.
- Owns its phase timer, driven by a one-cycle timebase strobe.
- Adds a mandatory all-red clearance phase.
- Adds a maximum-green cap so a busy approach cannot starve the others.
- Adds an emergency-vehicle override.
- Sits between the sensor conditioning logic and the lamp drivers.

## Interface
Parameters:
- NUM_DIR, 4: number of approaches (2..8); rotation order is 0,1,…,NUM_DIR-1.
- SENS_W, 2: width of each approach's traffic-density sensor value.
- CNT_W, 6: timer width; must hold MAX_GREEN.
- GREEN_TIME, 30: green slot length in ticks.
- ORANGE_TIME, 3: orange length in ticks.
- ALLRED_TIME, 1: all-red clearance length in ticks.
- MAX_GREEN, 60: cap on one approach's continuous green in ticks; ≥ GREEN_TIME.

Ports:
- clk  in  1  sole clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  timebase strobe, one cycle wide; the timer advances only when it is high.
- sens  in  NUM_DIR*SENS_W  density per approach; approach i occupies bits [i*SENS_W +: SENS_W]; unsigned.
- emerg_req  in  1  emergency request, level-sensitive.
- emerg_dir  in  clog2(NUM_DIR)  approach to be given the emergency green.
- lights  out  NUM_DIR*3  lamp state per approach, [i*3 +: 3]; 001 green, 010 orange, 100 red.
- active_dir  out  clog2(NUM_DIR)  approach currently holding green or orange.
- phase  out  2  00 GREEN, 01 ORANGE, 10 ALLRED.

## Operation
- Registered state: phase, cur_dir, nxt_dir, timer (CNT_W), green_acc (CNT_W).
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Lamp decode:
  - GREEN: approach cur_dir shows 001.
  - ORANGE: approach cur_dir shows 010.
  - ALLRED: every approach shows 100.
  - Every approach other than cur_dir shows 100 in all phases.
- Reset values: phase=GREEN, cur_dir=0, nxt_dir=0, timer=GREEN_TIME, green_acc=0, lights=dir0 001 and the rest 100, active_dir=0.
- Phase end: a cycle with tick=1 and timer==1. On any other tick, timer decrements. While tick=0, all state holds.
- Next-direction selection (combinational):
  - Scan approaches cur_dir+1, cur_dir+2, … modulo NUM_DIR, excluding cur_dir.
  - Pick the largest sens value; ties go to the first approach in scan order.
- GREEN, on every tick: green_acc increments.
- GREEN, at phase end:
  - Extend if sens[cur_dir] is strictly greater than every other approach AND green_acc+GREEN_TIME ≤ MAX_GREEN. Extension reloads timer=GREEN_TIME and stays in GREEN.
  - Otherwise go to ORANGE: latch nxt_dir = selection, load timer=ORANGE_TIME.
- ORANGE, at phase end: go to ALLRED, load timer=ALLRED_TIME.
- ALLRED, at phase end:
  - cur_dir = emerg_dir if emerg_req=1, else nxt_dir.
  - Go to GREEN, timer=GREEN_TIME, green_acc=0.
- Emergency override, checked every cycle regardless of tick:
  - GREEN with cur_dir≠emerg_dir and emerg_req=1: go to ORANGE on the next edge, timer=ORANGE_TIME, nxt_dir=emerg_dir.
  - GREEN with cur_dir==emerg_dir and emerg_req=1: timer is held at GREEN_TIME and green_acc held at 0. No phase end can occur and MAX_GREEN is ignored.
  - ORANGE or ALLRED: the phase runs to completion. The ALLRED exit rule then directs green to emerg_dir.
  - Release of emerg_req: normal countdown resumes from GREEN_TIME.
- Arithmetic: modulo-NUM_DIR increments wrap; green_acc saturates at its maximum value.

## Timing
- State updates one cycle after the qualifying edge. Lamp outputs change in the cycle after the transition edge.
- With tick=1 every cycle, phase durations are:
  - green: GREEN_TIME cycles per slot;
  - orange: ORANGE_TIME cycles;
  - all-red: ALLRED_TIME cycles.
- Emergency preemption latency: orange appears 1 cycle after emerg_req rises, independent of tick.
- Reset is synchronous: rst=1 in any state, mid-phase included, produces the reset state at the next edge. rst dominates emerg_req and tick.
- The lamps never go green→red or orange→green directly. Every green handover passes through ORANGE and then ALLRED.

## Test plan
- Defaults, tick=1, sens all 0:
  - dir0 green for 30 cycles, orange 3, all-red 1, then dir1 green.
  - Rotation continues 2,3,0.
  - active_dir and phase match at every cycle.
- sens A=3, B=C=D=1 from reset:
  - dir0 extends once (60 cycles of green), then is forced to orange at MAX_GREEN.
  - Next green is dir1, the tie winner in scan order.
- sens A=0, B=1, C=3, D=3, from dir0 at green end: ORANGE, ALLRED, then dir2 green (tie with D resolved in scan order).
- Emergency:
  - emerg_req=1, emerg_dir=2 at cycle 10 of dir0 green: orange at cycle 11, all-red, then dir2 green.
  - dir2 green holds indefinitely while the request is high.
  - After release, dir2 green runs 30 more cycles.
- tick pulsing 1-in-4: every phase lasts 4× its nominal cycle count; outputs are stable between ticks.
- rst pulsed mid-ORANGE of dir3: on the next edge, dir0 is green, phase=00, timer reloaded to 30, and the remaining lamps are red.
